// File: rtl/conv_sched_pkg.sv
// Shared types and default frame geometry for the camera-to-edge_conv frame scheduler.
// The camera front-end imports the same defaults so both sides agree on frame size.
package conv_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } sched_state_t;

    localparam int PIX_W_DEF     = 30;
    localparam int FRAME_PIX_DEF = 76800;
    localparam int FLUSH_PIX_DEF = 642;

    // One counter serves both the frame and the flush run, so it is sized for the longer one.
    function automatic int cnt_width(input int frame_pix, input int flush_pix);
        int longest;
        longest = (frame_pix > flush_pix) ? frame_pix : flush_pix;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin pick. The pick is combinational; the "last served"
// pointer only moves when the scheduler finishes a frame.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_i,
    input  logic       upd_i,
    input  logic       served_i,
    output logic       any_o,
    output logic       pick_o
);

    logic last_q;

    // Reset value claims cam1 was served last, so cam0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= 1'b1;
        end else if (upd_i) begin
            last_q <= served_i;
        end
    end

    always_comb begin
        any_o = |req_i;
        if (req_i == 2'b11) begin
            pick_o = ~last_q;
        end else begin
            pick_o = ~req_i[0];
        end
    end

endmodule

// File: rtl/conv_frame_sched.sv
// Grants the shared edge_conv input to one camera per frame, then injects a run
// of zero pixels to drain the convolution line buffers before re-arbitrating.
module conv_frame_sched
    import conv_sched_pkg::*;
#(
    parameter int W         = PIX_W_DEF,
    parameter int FRAME_PIX = FRAME_PIX_DEF,
    parameter int FLUSH_PIX = FLUSH_PIX_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [W-1:0] cam0_data,
    input  logic         cam0_valid,
    output logic         cam0_ready,
    input  logic [W-1:0] cam1_data,
    input  logic         cam1_valid,
    output logic         cam1_ready,
    output logic [W-1:0] y_data,
    output logic         y_valid,
    input  logic         y_ready,
    output logic         src,
    output logic         busy,
    output logic         frame_done
);

    localparam int            CW         = cnt_width(FRAME_PIX, FLUSH_PIX);
    localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_PIX - 1);
    localparam logic [CW-1:0] FLUSH_LAST = (FLUSH_PIX > 0) ? CW'(FLUSH_PIX - 1) : '0;

    sched_state_t  state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          src_q, src_d;
    logic          rr_any, rr_pick, rr_upd;

    rr_arb2 u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_i    ({cam1_valid, cam0_valid}),
        .upd_i    (rr_upd),
        .served_i (src_q),
        .any_o    (rr_any),
        .pick_o   (rr_pick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            src_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        src_d      = src_q;
        rr_upd     = 1'b0;
        y_data     = '0;
        y_valid    = 1'b0;
        cam0_ready = 1'b0;
        cam1_ready = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable && rr_any) begin
                    src_d   = rr_pick;
                    cnt_d   = '0;
                    state_d = PASS;
                end
            end

            PASS: begin
                y_data     = src_q ? cam1_data : cam0_data;
                y_valid    = src_q ? cam1_valid : cam0_valid;
                cam0_ready = ~src_q & y_ready;
                cam1_ready = src_q & y_ready;
                if (y_valid && y_ready) begin
                    if (cnt_q == FRAME_LAST) begin
                        cnt_d  = '0;
                        rr_upd = 1'b1;
                        if (FLUSH_PIX == 0) begin
                            frame_done = 1'b1;
                            state_d    = IDLE;
                        end else begin
                            state_d = FLUSH;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            FLUSH: begin
                // Zero pixels are offered unconditionally so valid never depends on ready.
                y_valid = 1'b1;
                if (y_ready) begin
                    if (cnt_q == FLUSH_LAST) begin
                        cnt_d      = '0;
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign src  = src_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_conv_frame_sched.sv
// Self-checking bench for conv_frame_sched: a frame-level model checked every cycle,
// plus directed scenarios with hand-computed expectations (FRAME_PIX=16, FLUSH_PIX=4).
module tb_conv_frame_sched;

    localparam int W  = 30;
    localparam int FP = 16;
    localparam int FL = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset, enable, c0v, c1v, yr;
    logic [W-1:0] c0d, c1d, yd;
    logic         c0r, c1r, yv, src, busy, fdone;

    logic         reset2, en2, v2, yr2, z1v;
    logic [W-1:0] d2, yd2, z1d;
    logic         c0r2, c1r2, yv2, src2, busy2, fd2;

    conv_frame_sched #(.W(W), .FRAME_PIX(FP), .FLUSH_PIX(FL)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .cam0_data(c0d), .cam0_valid(c0v), .cam0_ready(c0r),
        .cam1_data(c1d), .cam1_valid(c1v), .cam1_ready(c1r),
        .y_data(yd), .y_valid(yv), .y_ready(yr),
        .src(src), .busy(busy), .frame_done(fdone)
    );

    conv_frame_sched #(.W(W), .FRAME_PIX(FP), .FLUSH_PIX(0)) dut2 (
        .clk(clk), .reset(reset2), .enable(en2),
        .cam0_data(d2), .cam0_valid(v2), .cam0_ready(c0r2),
        .cam1_data(z1d), .cam1_valid(z1v), .cam1_ready(c1r2),
        .y_data(yd2), .y_valid(yv2), .y_ready(yr2),
        .src(src2), .busy(busy2), .frame_done(fd2)
    );

    int total = 0;
    int bad   = 0;
    logic cmp_on = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: phase 0 idle, 1 camera frame, 2 zero drain; m_left counts down.
    int   m_phase = 0;
    int   m_left  = 0;
    logic m_cam   = 1'b0;
    logic m_last  = 1'b1;
    int   idx0 = 0, idx1 = 0, idx2 = 0;

    always_comb begin
        c0d = 30'h0100_0000 + W'(idx0);
        c1d = 30'h0200_0000 + W'(idx1);
        d2  = 30'h0000_0300 + W'(idx2);
    end

    logic         e_valid, e_r0, e_r1, e_busy, e_done;
    logic [W-1:0] e_data;

    always_comb begin
        e_valid = 1'b0;
        e_data  = '0;
        e_r0    = 1'b0;
        e_r1    = 1'b0;
        e_done  = 1'b0;
        e_busy  = (m_phase != 0);
        if (m_phase == 1) begin
            e_valid = m_cam ? c1v : c0v;
            e_data  = m_cam ? c1d : c0d;
            e_r0    = !m_cam && yr;
            e_r1    = m_cam && yr;
        end else if (m_phase == 2) begin
            e_valid = 1'b1;
            e_done  = yr && (m_left == 1);
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_left = 0; m_cam = 1'b0; m_last = 1'b1; idx0 = 0; idx1 = 0;
        end else begin
            case (m_phase)
                0: if (enable && (c0v || c1v)) begin
                    m_cam   = (c0v && c1v) ? !m_last : !c0v;
                    m_phase = 1;
                    m_left  = FP;
                end
                1: if (e_valid && yr) begin
                    if (m_cam) idx1++; else idx0++;
                    m_left--;
                    if (m_left == 0) begin
                        m_last  = m_cam;
                        m_phase = 2;
                        m_left  = FL;
                    end
                end
                default: if (yr) begin
                    m_left--;
                    if (m_left == 0) m_phase = 0;
                end
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset2) idx2 = 0;
        else if (c0r2 && v2) idx2++;
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            checkOutput("y_valid", 32'(yv), 32'(e_valid));
            if (m_phase != 0) checkOutput("y_data", 32'(yd), 32'(e_data));
            checkOutput("cam0_ready", 32'(c0r), 32'(e_r0));
            checkOutput("cam1_ready", 32'(c1r), 32'(e_r1));
            checkOutput("busy", 32'(busy), 32'(e_busy));
            checkOutput("src", 32'(src), 32'(m_cam));
            checkOutput("frame_done", 32'(fdone), 32'(e_done));
        end
    end

    // Transfer monitor: transfers per frame and the source at each frame_done.
    int   xfer = 0;
    int   done_len[$];
    logic done_src[$];

    always @(posedge clk) begin
        if (reset) begin
            xfer = 0;
        end else if (yv && yr) begin
            xfer++;
            if (fdone) begin
                done_len.push_back(xfer);
                done_src.push_back(src);
                xfer = 0;
            end
        end
    end

    task automatic applyStimulus(input logic en, input logic v0, input logic v1);
        enable = en;
        c0v    = v0;
        c1v    = v1;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic waitXfers(input int n);
        int k = 0;
        while (xfer < n && k < 500) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("xfer_reached", 32'(xfer), 32'(n));
    endtask

    task automatic waitDone(input int prev);
        int k = 0;
        while (done_len.size() <= prev && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        checkOutput("frame_done_seen", 32'(done_len.size()), 32'(prev + 1));
    endtask

    task automatic stallFor(input int cyc, input logic [W-1:0] exp_data, input string name);
        yr = 1'b0;
        @(negedge clk);
        checkOutput({name, "_data"}, 32'(yd), 32'(exp_data));
        checkOutput({name, "_valid"}, 32'(yv), 32'd1);
        repeat (cyc) begin
            @(posedge clk); #1;
        end
        yr = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n, k, cyc;
        reset = 1'b1; yr = 1'b1; applyStimulus(1'b0, 1'b0, 1'b0);
        reset2 = 1'b1; en2 = 1'b0; v2 = 1'b0; yr2 = 1'b1; z1v = 1'b0; z1d = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cmp_on = 1'b1;

        @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_y_valid", 32'(yv), 32'd0);
        checkOutput("rst_ready", 32'({c1r, c0r}), 32'd0);
        checkOutput("rst_src", 32'(src), 32'd0);
        checkOutput("rst_frame_done", 32'(fdone), 32'd0);

        // Single camera frame: 16 pixels then 4 zeros, done on transfer 20.
        @(posedge clk); #1;
        n = done_len.size();
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s1_not_yet_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("s1_grant_busy", 32'(busy), 32'd1);
        checkOutput("s1_first_pixel", 32'(yd), 32'h0100_0000);
        waitDone(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s1_len", 32'(done_len[n]), 32'd20);
        checkOutput("s1_src", 32'(done_src[n]), 32'd0);
        @(negedge clk);
        checkOutput("s1_busy_after", 32'(busy), 32'd0);

        // Both cameras valid: cam0, cam1, cam0.
        doReset();
        n = done_len.size();
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitDone(n);
        waitDone(n + 1);
        waitDone(n + 2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("s2_len", 32'(done_len[n + i]), 32'd20);
            checkOutput("s2_src", 32'(done_src[n + i]), 32'(i == 1));
        end

        // Stalls at pixel 8 and flush pixel 2.
        doReset();
        n = done_len.size();
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitXfers(8);
        stallFor(5, 30'h0100_0008, "s3_stall_pass");
        waitXfers(18);
        stallFor(5, 30'h0, "s3_stall_flush");
        waitDone(n);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("s3_len", 32'(done_len[n]), 32'd20);

        // Enable dropped mid-frame: frame completes, no regrant until re-enabled.
        doReset();
        n = done_len.size();
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitXfers(3);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitDone(n);
        checkOutput("s4_len", 32'(done_len[n]), 32'd20);
        repeat (5) begin
            @(negedge clk);
            checkOutput("s4_idle_busy", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("s4_reen_busy0", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("s4_reen_busy1", 32'(busy), 32'd1);

        // Reset at pixel 10 aborts the frame without frame_done.
        n = done_len.size();
        @(posedge clk); #1;
        waitXfers(10);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("s5_busy", 32'(busy), 32'd0);
        checkOutput("s5_y_valid", 32'(yv), 32'd0);
        checkOutput("s5_ready", 32'({c1r, c0r}), 32'd0);
        checkOutput("s5_frame_done", 32'(fdone), 32'd0);
        checkOutput("s5_src", 32'(src), 32'd0);
        waitDone(n);
        checkOutput("s5_len", 32'(done_len[n]), 32'd20);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // FLUSH_PIX=0 build: done on the 16th pixel, no zero pixels.
        @(posedge clk); #1;
        reset2 = 1'b0;
        en2 = 1'b1;
        v2  = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 16 && cyc < 100) begin
            @(negedge clk);
            if (yv2 && yr2) begin
                k++;
                checkOutput("s6_data", 32'(yd2), 32'h300 + 32'(k - 1));
                checkOutput("s6_done", 32'(fd2), 32'(k == 16));
            end
            cyc++;
        end
        checkOutput("s6_count", 32'(k), 32'd16);
        @(negedge clk);
        checkOutput("s6_busy_after", 32'(busy2), 32'd0);
        checkOutput("s6_y_valid_after", 32'(yv2), 32'd0);
        en2 = 1'b0;
        v2  = 1'b0;

        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
